// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: groups the buses of the fetch sequencer.
//   ROM side    : pc_vld / pc out to pre_fetch, pre_instr back (one-cycle latency)
//   decode side : instr_vld / instr / instr_pc out, instr_rdy back
// master = fetch_ctrl, slave = pre_fetch + decode environment.
interface fetch_ctrl_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32
);
  logic               pc_vld;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] pre_instr;
  logic               instr_vld;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_rdy;

  modport master (
    output pc_vld, pc, instr_vld, instr, instr_pc,
    input  pre_instr, instr_rdy
  );

  modport slave (
    input  pc_vld, pc, instr_vld, instr, instr_pc,
    output pre_instr, instr_rdy
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer in front of the instruction ROM stage.
// Issues pc/pc_vld to pre_fetch, marks the returning pre_instr valid one cycle
// later (v1), and buffers {instr, pc} in a small FIFO towards decode.
// Handles start / halt / branch redirect with flush and out-of-range PCs.
// Ports:
//   clk, rst_n        clock; synchronous reset, active HIGH despite the name
//   start             pulse: leave IDLE (from RESET_PC) or HALT (from saved PC)
//   halt_req          stop issuing, enter HALT
//   branch_vld/_pc    redirect + flush (ignored in IDLE)
//   busy              state is RUN
//   pc_oob            sticky out-of-range PC flag, cleared by reset or start
//   bus (master)      pc_vld/pc/pre_instr and instr_vld/instr/instr_pc/instr_rdy
//
// state | meaning
// IDLE  | after reset, nothing fetched yet
// RUN   | issuing fetches while FIFO credit allows
// HALT  | halted by request or bad PC; FIFO keeps draining
module fetch_ctrl #(
  parameter int PC_W       = 8,
  parameter int INSTR_W    = 32,
  parameter int ROM_DEPTH  = 256,
  parameter int RESET_PC   = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            halt_req,
  input  logic            branch_vld,
  input  logic [PC_W-1:0] branch_pc,
  output logic            busy,
  output logic            pc_oob,
  fetch_ctrl_if.master    bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [PC_W:0]      ROM_LIM  = (PC_W+1)'(ROM_DEPTH);
  localparam logic [PC_W:0]      RST_PC   = (PC_W+1)'(RESET_PC);
  localparam logic [PC_W:0]      PC_ONE   = (PC_W+1)'(1);
  localparam logic [OCC_W-1:0]   OCC_LIM  = OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t            state_q, state_d;
  // next PC to issue; one bit wider so the end-of-ROM check never wraps
  logic [PC_W:0]     npc_q, npc_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              pc_vld_q;
  logic              v1_q;
  logic [PC_W-1:0]   tag_q;
  logic              oob_q;

  logic [INSTR_W-1:0] mem_instr [FIFO_DEPTH];
  logic [PC_W-1:0]    mem_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic              active, redirect, oob_hit, issue;
  logic [PC_W:0]     cand;
  logic [OCC_W-1:0]  occ;
  logic              fifo_wr, fifo_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // start in RUN changes nothing, so it is safe to fold it into "active"
  always_comb begin
    state_d  = state_q;
    npc_d    = npc_q;
    pc_d     = pc_q;
    cand     = npc_q;
    occ      = '0;
    active   = (state_q == S_RUN) || start;
    redirect = branch_vld && (state_q != S_IDLE);
    if (state_q == S_IDLE)
      cand = RST_PC;
    else if (redirect)
      cand = {1'b0, branch_pc};
    oob_hit = (active || redirect) && (cand >= ROM_LIM);
    // credit from registered occupancy only; a flush empties everything
    if (!redirect)
      occ = {1'b0, cnt_q} + OCC_W'(pc_vld_q) + OCC_W'(v1_q);
    issue = active && !halt_req && !oob_hit && (occ < OCC_LIM);
    if (oob_hit || (active && halt_req))
      state_d = S_HALT;
    else if (active)
      state_d = S_RUN;
    if (issue) begin
      npc_d = cand + PC_ONE;
      pc_d  = cand[PC_W-1:0];
    end else if (redirect || ((state_q == S_IDLE) && start)) begin
      npc_d = cand;
    end
  end

  assign fifo_pop = (cnt_q != '0) && bus.instr_rdy;
  // an entry in flight during a redirect belongs to the old path
  assign fifo_wr  = v1_q && !redirect;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= S_IDLE;
      npc_q    <= RST_PC;
      pc_q     <= RST_PC[PC_W-1:0];
      pc_vld_q <= 1'b0;
      v1_q     <= 1'b0;
      tag_q    <= '0;
      oob_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      npc_q    <= npc_d;
      pc_q     <= pc_d;
      pc_vld_q <= issue;
      v1_q     <= pc_vld_q && !redirect;
      tag_q    <= pc_q;
      if (oob_hit)
        oob_q <= 1'b1;
      else if (start)
        oob_q <= 1'b0;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (fifo_wr)
          wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (fifo_pop)
          rd_ptr_q <= ptr_inc(rd_ptr_q);
        case ({fifo_wr, fifo_pop})
          2'b10:   cnt_q <= cnt_q + CNT_W'(1);
          2'b01:   cnt_q <= cnt_q - CNT_W'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end
  end

  // storage needs no reset: the read port is masked while empty
  always_ff @(posedge clk) begin
    if (!rst_n && fifo_wr) begin
      mem_instr[wr_ptr_q] <= bus.pre_instr;
      mem_pc[wr_ptr_q]    <= tag_q;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst_n)
    !(fifo_wr && !fifo_pop && (cnt_q == CNT_FULL)));

  assign bus.pc        = pc_q;
  assign bus.pc_vld    = pc_vld_q;
  assign bus.instr_vld = (cnt_q != '0);
  assign bus.instr     = bus.instr_vld ? mem_instr[rd_ptr_q] : '0;
  assign bus.instr_pc  = bus.instr_vld ? mem_pc[rd_ptr_q] : '0;
  assign busy          = (state_q == S_RUN);
  assign pc_oob        = oob_q;

endmodule
